lcd_ctrl_param: RTL and testbench
=================================

// Module: lcd_ctrl_param
// PURPOSE
//   Parametrised image display controller and next generation of the fixed 8x8 LCD controller.
//   - Loads a 2^AW_X x 2^AW_Y image of DW-bit pixels from IROM into an internal buffer.
//   - Executes 2x2-window commands around an operation point (OP).
//   - Streams the processed image to IRAM on Write.
//   - New in this generation: the image stays valid after Write, so further commands are accepted.
//   - New commands: Clear, Centre and Median.
// PARAMETERS
//   DW    8  pixel width, bits
//   AW_X  3  log2 image width W (W = 2^AW_X), >= 2
//   AW_Y  3  log2 image height H (H = 2^AW_Y), >= 2
// PORTS
//   clk         in   1          rising-edge clock
//   reset       in   1          asynchronous, active-low reset
//   cmd         in   4          command code
//   cmd_valid   in   1          cmd qualifier; sampled only while busy==0
//   IROM_Q      in   DW         ROM read data, valid the cycle after IROM_A
//   IROM_rd     out  1          ROM read enable
//   IROM_A      out  AW_X+AW_Y  ROM address, row-major ({y,x})
//   IRAM_valid  out  1          RAM write strobe
//   IRAM_D      out  DW         RAM write data
//   IRAM_A      out  AW_X+AW_Y  RAM write address, row-major
//   busy        out  1          1 = command not accepted
//   done        out  1          one-cycle pulse when Write completes
// BEHAVIOUR
//   Reset (reset==0, asynchronous):
//   - busy=1, done=0, IROM_rd=0, IRAM_valid=0, IROM_A=0, IRAM_A=0, IRAM_D=0.
//   - OP=(W/2,H/2); FSM=LOAD; buffer contents undefined.
//   - Reset asserted mid-LOAD, mid-OUT or mid-EXEC aborts the operation and restarts LOAD.
//   FSM states and transitions:
//   - LOAD -> IDLE: IROM_rd=1 and IROM_A=0..N-1 (N=W*H), one address per cycle.
//     Buffer captures IROM_Q one cycle later; IDLE is entered after the final capture (N+1 cycles).
//   - IDLE: busy=0. cmd_valid==1 latches cmd and moves to EXEC, or to OUT if cmd==0.
//     busy=1 from the next edge.
//   - EXEC -> IDLE: one cycle, command applied. busy is high for exactly 1 cycle per non-Write command.
//   - OUT -> IDLE: N cycles. IRAM_valid=1, IRAM_A=0..N-1, IRAM_D=buffer[IRAM_A].
//     On the edge after the last beat: done=1 for 1 cycle, busy=0 in the same cycle, buffer retained.
//   - cmd_valid while busy==1 is ignored (no queuing).
//   Window definition:
//   - P0=(ox-1,oy-1), P1=(ox,oy-1), P2=(ox-1,oy), P3=(ox,oy).
//   - OP range: ox in [1,W-1], oy in [1,H-1]. Shifts saturate at the bounds; no wrap.
//   Commands:
//   - 0 Write
//   - 1 Up (oy-1), 2 Down (oy+1), 3 Left (ox-1), 4 Right (ox+1)
//   - 5 Max, 6 Min: all four pixels set to the max/min.
//   - 7 Average: floor(sum/4); sum computed at DW+2 bits, no overflow.
//   - 8 CCW rotate: P0<-P1, P1<-P3, P2<-P0, P3<-P2
//   - 9 CW rotate: P0<-P2, P1<-P0, P2<-P3, P3<-P1
//   - 10 Mirror X: swap rows. 11 Mirror Y: swap columns.
//   - 12 Clear: all four pixels set to 0.
//   - 13 Centre: OP=(W/2,H/2).
//   - 14 Median: all four set to floor((second smallest + second largest)/2).
//   - 15 reserved: no-op, 1 busy cycle.
//   Equal-value ties in Max/Min/Median give identical results regardless of position.
// TESTING
//   - Ramp: ROM[i]=i, W=H=8. After busy falls, Write -> IRAM_A 0..63 with IRAM_D=i; done 1 cycle; busy 64 cycles.
//   - Saturation: 5x Up then 5x Left from reset -> OP=(1,1). Max then Write -> ROM pixels 0,1,8,9 all read back as 9.
//   - Average on ramp at OP=(4,4): pixels 27,28,35,36 -> all 31. Median -> all 31. Clear -> all 0.
//   - CW then CCW at OP=(4,4) -> image unchanged. MirrorX twice -> image unchanged.
//   - DW=8, all pixels 255, Average -> 255 (no overflow). Width check repeated with AW_X=4, AW_Y=3: 128 output beats.
//   - Reset pulsed at beat 20 of Write -> IRAM_valid drops at once, LOAD restarts at IROM_A=0.
//     cmd_valid held during busy is ignored.

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: parametrised 2x2-window image display controller.
// Loads an image from IROM, edits it around OP, streams it to IRAM.
module lcd_ctrl_param #(
    parameter int DW   = 8,
    parameter int AW_X = 3,
    parameter int AW_Y = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           cmd,
    input  logic                 cmd_valid,
    input  logic [DW-1:0]        IROM_Q,
    output logic                 IROM_rd,
    output logic [AW_X+AW_Y-1:0] IROM_A,
    output logic                 IRAM_valid,
    output logic [DW-1:0]        IRAM_D,
    output logic [AW_X+AW_Y-1:0] IRAM_A,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = AW_X + AW_Y;
    localparam int N  = 1 << AW;

    localparam logic [AW:0]     N_L    = (AW+1)'(N);
    localparam logic [AW:0]     LD_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]   A_LAST = AW'(N - 1);
    localparam logic [AW-1:0]   A_ONE  = AW'(1);
    localparam logic [AW_X-1:0] X_ONE  = AW_X'(1);
    localparam logic [AW_X-1:0] X_MAX  = AW_X'((1 << AW_X) - 1);
    localparam logic [AW_X-1:0] X_MID  = AW_X'(1 << (AW_X - 1));
    localparam logic [AW_Y-1:0] Y_ONE  = AW_Y'(1);
    localparam logic [AW_Y-1:0] Y_MAX  = AW_Y'((1 << AW_Y) - 1);
    localparam logic [AW_Y-1:0] Y_MID  = AW_Y'(1 << (AW_Y - 1));

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [3:0] C_WRITE = 4'd0;
    localparam logic [3:0] C_UP    = 4'd1;
    localparam logic [3:0] C_DOWN  = 4'd2;
    localparam logic [3:0] C_LEFT  = 4'd3;
    localparam logic [3:0] C_RIGHT = 4'd4;
    localparam logic [3:0] C_MAX   = 4'd5;
    localparam logic [3:0] C_MIN   = 4'd6;
    localparam logic [3:0] C_AVG   = 4'd7;
    localparam logic [3:0] C_CCW   = 4'd8;
    localparam logic [3:0] C_CW    = 4'd9;
    localparam logic [3:0] C_MIRX  = 4'd10;
    localparam logic [3:0] C_MIRY  = 4'd11;
    localparam logic [3:0] C_CLEAR = 4'd12;
    localparam logic [3:0] C_CTR   = 4'd13;
    localparam logic [3:0] C_MED   = 4'd14;

    logic [1:0]      state_q, state_d;
    logic            busy_q, done_q;
    logic            rd_q;
    logic [AW-1:0]   roma_q;
    logic [AW:0]     ld_q;
    logic            cap_v_q;
    logic [AW-1:0]   cap_a_q;
    logic [AW_X-1:0] ox_q;
    logic [AW_Y-1:0] oy_q;
    logic [3:0]      cmd_q;
    logic            val_q;
    logic [AW-1:0]   rama_q;
    logic [DW-1:0]   ramd_q;

    logic [DW-1:0]   mem_q [N];

    logic [AW_X-1:0] xm1;
    logic [AW_Y-1:0] ym1;
    logic [AW-1:0]   i0, i1, i2, i3;
    logic [DW-1:0]   p0, p1, p2, p3;
    logic [DW-1:0]   n0, n1, n2, n3;
    logic            win_we;
    logic [DW-1:0]   mx, mn, avg, med;
    logic [DW+1:0]   sum;
    logic [DW:0]     mid2;

    assign IROM_rd    = rd_q;
    assign IROM_A     = roma_q;
    assign IRAM_valid = val_q;
    assign IRAM_A     = rama_q;
    assign IRAM_D     = ramd_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Window corners, row-major {y,x}; OP never sits on row/column 0.
    assign xm1 = ox_q - X_ONE;
    assign ym1 = oy_q - Y_ONE;
    assign i0  = {ym1, xm1};
    assign i1  = {ym1, ox_q};
    assign i2  = {oy_q, xm1};
    assign i3  = {oy_q, ox_q};
    assign p0  = mem_q[i0];
    assign p1  = mem_q[i1];
    assign p2  = mem_q[i2];
    assign p3  = mem_q[i3];

    // Next FSM state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: if (cap_v_q && cap_a_q == A_LAST) state_d = S_IDLE;
            S_IDLE: if (cmd_valid) state_d = (cmd == C_WRITE) ? S_OUT : S_EXEC;
            S_EXEC: state_d = S_IDLE;
            S_OUT:  if (rama_q == A_LAST) state_d = S_IDLE;
            default: state_d = S_LOAD;
        endcase
    end

    // Window statistics; median is (sum - max - min) / 2.
    always_comb begin
        mx = p0;
        mn = p0;
        if (p1 > mx) mx = p1;
        if (p2 > mx) mx = p2;
        if (p3 > mx) mx = p3;
        if (p1 < mn) mn = p1;
        if (p2 < mn) mn = p2;
        if (p3 < mn) mn = p3;
        sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
        avg  = sum[DW+1:2];
        mid2 = (DW+1)'(sum - {2'b00, mx} - {2'b00, mn});
        med  = DW'(mid2 >> 1);
    end

    // New window contents for the latched command.
    always_comb begin
        n0 = p0;
        n1 = p1;
        n2 = p2;
        n3 = p3;
        win_we = 1'b1;
        case (cmd_q)
            C_MAX:   begin n0 = mx;  n1 = mx;  n2 = mx;  n3 = mx;  end
            C_MIN:   begin n0 = mn;  n1 = mn;  n2 = mn;  n3 = mn;  end
            C_AVG:   begin n0 = avg; n1 = avg; n2 = avg; n3 = avg; end
            C_MED:   begin n0 = med; n1 = med; n2 = med; n3 = med; end
            C_CLEAR: begin n0 = '0;  n1 = '0;  n2 = '0;  n3 = '0;  end
            C_CCW:   begin n0 = p1;  n1 = p3;  n2 = p0;  n3 = p2;  end
            C_CW:    begin n0 = p2;  n1 = p0;  n2 = p3;  n3 = p1;  end
            C_MIRX:  begin n0 = p2;  n1 = p3;  n2 = p0;  n3 = p1;  end
            C_MIRY:  begin n0 = p1;  n1 = p0;  n2 = p3;  n3 = p2;  end
            default: win_we = 1'b0;
        endcase
    end

    // Image buffer: ROM capture during LOAD, window update in EXEC.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && cap_v_q) begin
            mem_q[cap_a_q] <= IROM_Q;
        end else if (state_q == S_EXEC && win_we) begin
            mem_q[i0] <= n0;
            mem_q[i1] <= n1;
            mem_q[i2] <= n2;
            mem_q[i3] <= n3;
        end
    end

    // Control, ROM address stream, RAM output stream and OP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            roma_q  <= '0;
            ld_q    <= '0;
            cap_v_q <= 1'b0;
            cap_a_q <= '0;
            ox_q    <= X_MID;
            oy_q    <= Y_MID;
            cmd_q   <= '0;
            val_q   <= 1'b0;
            rama_q  <= '0;
            ramd_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_q == S_OUT) && (state_d == S_IDLE);
            cap_v_q <= rd_q;
            cap_a_q <= roma_q;
            rd_q    <= 1'b0;
            if (state_q == S_LOAD && ld_q < N_L) begin
                rd_q   <= 1'b1;
                roma_q <= ld_q[AW-1:0];
                ld_q   <= ld_q + LD_ONE;
            end
            if (state_q == S_IDLE && cmd_valid) begin
                cmd_q <= cmd;
                if (cmd == C_WRITE) begin
                    val_q  <= 1'b1;
                    rama_q <= '0;
                    ramd_q <= mem_q[0];
                end
            end
            if (state_q == S_OUT) begin
                if (rama_q == A_LAST) begin
                    val_q <= 1'b0;
                end else begin
                    rama_q <= rama_q + A_ONE;
                    ramd_q <= mem_q[rama_q + A_ONE];
                end
            end
            if (state_q == S_EXEC) begin
                case (cmd_q)
                    C_UP:    if (oy_q != Y_ONE) oy_q <= oy_q - Y_ONE;
                    C_DOWN:  if (oy_q != Y_MAX) oy_q <= oy_q + Y_ONE;
                    C_LEFT:  if (ox_q != X_ONE) ox_q <= ox_q - X_ONE;
                    C_RIGHT: if (ox_q != X_MAX) ox_q <= ox_q + X_ONE;
                    C_CTR: begin
                        ox_q <= X_MID;
                        oy_q <= Y_MID;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: directed bench with an image-level reference model.
// Main DUT is 8x8; a 16x8 instance checks the wider address path.
module tb_lcd_ctrl_param;

    localparam int W  = 8;
    localparam int NP = 64;
    localparam int NB = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] IROM_Q;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic       IRAM_valid;
    logic [7:0] IRAM_D;
    logic [5:0] IRAM_A;
    logic       busy;
    logic       done;

    logic [3:0] cmd_b;
    logic       cmd_valid_b;
    logic [7:0] IROM_Q_b;
    logic       IROM_rd_b;
    logic [6:0] IROM_A_b;
    logic       IRAM_valid_b;
    logic [7:0] IRAM_D_b;
    logic [6:0] IRAM_A_b;
    logic       busy_b;
    logic       done_b;

    always #5 clk = ~clk;

    lcd_ctrl_param #(.DW(8), .AW_X(3), .AW_Y(3)) u_dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(IROM_Q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
        .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
        .busy(busy), .done(done)
    );

    lcd_ctrl_param #(.DW(8), .AW_X(4), .AW_Y(3)) u_wide (
        .clk(clk), .reset(reset), .cmd(cmd_b), .cmd_valid(cmd_valid_b),
        .IROM_Q(IROM_Q_b), .IROM_rd(IROM_rd_b), .IROM_A(IROM_A_b),
        .IRAM_valid(IRAM_valid_b), .IRAM_D(IRAM_D_b), .IRAM_A(IRAM_A_b),
        .busy(busy_b), .done(done_b)
    );

    logic [7:0] rom_a [NP];
    logic [7:0] rom_b [NB];

    always @(posedge clk) if (IROM_rd) IROM_Q <= rom_a[IROM_A];
    always @(posedge clk) if (IROM_rd_b) IROM_Q_b <= rom_b[IROM_A_b];

    typedef struct {
        int a;
        int d;
    } beat_t;

    int    vec  = 0;
    int    miss = 0;
    int    img [NP];
    int    ox, oy;
    int    rd_exp;
    int    ram_cap [NP];
    beat_t q [$];
    beat_t e;

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Per-cycle compare: ROM address sequence and IRAM beats vs model.
    always @(negedge clk) begin
        if (reset) begin
            if (IROM_rd) begin
                chk("rom_addr", int'(IROM_A), rd_exp);
                rd_exp++;
            end
            if (IRAM_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("ram_addr", int'(IRAM_A), e.a);
                    chk("ram_data", int'(IRAM_D), e.d);
                end
                ram_cap[IRAM_A] = int'(IRAM_D);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NP; i++) img[i] = int'(rom_a[i]);
        ox = W / 2;
        oy = W / 2;
    endtask

    task automatic model_cmd(input int c);
        int idx [4];
        int p [4];
        int s [4];
        int t;
        idx[0] = (oy - 1) * W + ox - 1;
        idx[1] = (oy - 1) * W + ox;
        idx[2] = oy * W + ox - 1;
        idx[3] = oy * W + ox;
        for (int i = 0; i < 4; i++) begin
            p[i] = img[idx[i]];
            s[i] = p[i];
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        case (c)
            1: if (oy > 1) oy--;
            2: if (oy < W - 1) oy++;
            3: if (ox > 1) ox--;
            4: if (ox < W - 1) ox++;
            5: for (int i = 0; i < 4; i++) img[idx[i]] = s[3];
            6: for (int i = 0; i < 4; i++) img[idx[i]] = s[0];
            7: for (int i = 0; i < 4; i++)
                   img[idx[i]] = (p[0] + p[1] + p[2] + p[3]) / 4;
            8: begin
                img[idx[0]] = p[1]; img[idx[1]] = p[3];
                img[idx[2]] = p[0]; img[idx[3]] = p[2];
            end
            9: begin
                img[idx[0]] = p[2]; img[idx[1]] = p[0];
                img[idx[2]] = p[3]; img[idx[3]] = p[1];
            end
            10: begin
                img[idx[0]] = p[2]; img[idx[1]] = p[3];
                img[idx[2]] = p[0]; img[idx[3]] = p[1];
            end
            11: begin
                img[idx[0]] = p[1]; img[idx[1]] = p[0];
                img[idx[2]] = p[3]; img[idx[3]] = p[2];
            end
            12: for (int i = 0; i < 4; i++) img[idx[i]] = 0;
            13: begin ox = W / 2; oy = W / 2; end
            14: for (int i = 0; i < 4; i++) img[idx[i]] = (s[1] + s[2]) / 2;
            default: ;
        endcase
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_rom_rd", int'(IROM_rd), 0);
        chk("rst_ram_valid", int'(IRAM_valid), 0);
        chk("rst_rom_addr", int'(IROM_A), 0);
        chk("rst_ram_addr", int'(IRAM_A), 0);
        chk("rst_ram_data", int'(IRAM_D), 0);
        q.delete();
        rd_exp = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wait_idle(300);
        chk("load_reads", rd_exp, NP);
    endtask

    task automatic send(input int c, input bit hold);
        int n;
        cmd = 4'(c);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) cmd = 4'd12;
        else cmd_valid = 1'b0;
        if (c == 0) begin
            for (int i = 0; i < NP; i++) q.push_back('{a: i, d: img[i]});
        end else begin
            model_cmd(c);
        end
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("busy_len", n, (c == 0) ? NP : 1);
        chk("done", int'(done), (c == 0) ? 1 : 0);
        if (c == 0) begin
            chk("beats_left", q.size(), 0);
            @(negedge clk);
            chk("done_pulse", int'(done), 0);
        end
    endtask

    initial begin
        int n;
        int beats;
        bit seen_done;

        reset = 1'b1;
        cmd = '0;
        cmd_valid = 1'b0;
        cmd_b = '0;
        cmd_valid_b = 1'b0;
        for (int i = 0; i < NP; i++) rom_a[i] = 8'(i);
        for (int i = 0; i < NB; i++) rom_b[i] = 8'(i);

        do_reset();

        // Wider image: 128 beats, addresses 0..127, ramp data.
        n = 0;
        while (busy_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wide_load", int'(busy_b), 0);
        cmd_b = 4'd0;
        cmd_valid_b = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_b = 1'b0;
        beats = 0;
        seen_done = 1'b0;
        n = 0;
        while (!seen_done && n < 300) begin
            @(negedge clk);
            n++;
            if (IRAM_valid_b) begin
                chk("wide_addr", int'(IRAM_A_b), beats);
                chk("wide_data", int'(IRAM_D_b), beats);
                beats++;
            end
            if (done_b) seen_done = 1'b1;
        end
        chk("wide_beats", beats, NB);
        chk("wide_done", int'(seen_done), 1);

        send(0, 1'b0);
        chk("ramp_px0", ram_cap[0], 0);
        chk("ramp_px63", ram_cap[63], 63);

        repeat (5) send(1, 1'b0);
        repeat (5) send(3, 1'b0);
        chk("sat_ox", ox, 1);
        chk("sat_oy", oy, 1);
        send(5, 1'b0);
        send(0, 1'b0);
        chk("max_px0", ram_cap[0], 9);
        chk("max_px1", ram_cap[1], 9);
        chk("max_px8", ram_cap[8], 9);
        chk("max_px9", ram_cap[9], 9);

        do_reset();
        send(7, 1'b0);
        send(0, 1'b0);
        chk("avg_px27", ram_cap[27], 31);
        chk("avg_px28", ram_cap[28], 31);
        chk("avg_px35", ram_cap[35], 31);
        chk("avg_px36", ram_cap[36], 31);

        do_reset();
        send(14, 1'b0);
        send(0, 1'b0);
        chk("med_px27", ram_cap[27], 31);
        chk("med_px36", ram_cap[36], 31);
        send(12, 1'b0);
        send(0, 1'b0);
        chk("clr_px27", ram_cap[27], 0);
        chk("clr_px36", ram_cap[36], 0);

        do_reset();
        send(9, 1'b0);
        send(0, 1'b0);
        chk("cw_px27", ram_cap[27], 35);
        chk("cw_px28", ram_cap[28], 27);
        send(8, 1'b0);
        send(0, 1'b0);
        chk("ccw_px27", ram_cap[27], 27);
        chk("ccw_px36", ram_cap[36], 36);
        send(10, 1'b0);
        send(0, 1'b0);
        chk("mirx_px27", ram_cap[27], 35);
        send(10, 1'b0);
        send(0, 1'b0);
        chk("mirx2_px27", ram_cap[27], 27);
        send(11, 1'b0);
        send(0, 1'b0);
        chk("miry_px27", ram_cap[27], 28);

        repeat (5) send(4, 1'b0);
        repeat (5) send(2, 1'b0);
        send(5, 1'b0);
        send(0, 1'b0);
        chk("corner_px54", ram_cap[54], 63);
        chk("corner_px63", ram_cap[63], 63);

        send(13, 1'b0);
        send(15, 1'b0);
        send(6, 1'b0);
        send(0, 1'b1);
        chk("min_px36", ram_cap[36], 27);
        send(0, 1'b0);
        chk("hold_px27", ram_cap[27], 27);

        for (int i = 0; i < NP; i++) rom_a[i] = 8'hFF;
        do_reset();
        send(7, 1'b0);
        send(0, 1'b0);
        chk("avg255_px27", ram_cap[27], 255);
        chk("avg255_px0", ram_cap[0], 255);

        // Reset during Write at beat 20 aborts output and restarts LOAD.
        for (int i = 0; i < NP; i++) rom_a[i] = 8'(i);
        do_reset();
        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < NP; i++) q.push_back('{a: i, d: img[i]});
        n = 0;
        while (!(IRAM_valid && IRAM_A == 6'd20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("beat20_seen", int'(IRAM_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_valid", int'(IRAM_valid), 0);
        chk("abort_busy", int'(busy), 1);
        chk("abort_rom_addr", int'(IROM_A), 0);
        q.delete();
        rd_exp = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wait_idle(300);
        chk("reload_reads", rd_exp, NP);
        send(0, 1'b0);
        chk("reload_px20", ram_cap[20], 20);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
